compute_dispatch: RTL

COMPUTE_DISPATCH -- requirements
Module: compute_dispatch

---
 rtl/compute_dispatch_if.sv | 30 +++
 rtl/compute_dispatch.sv | 122 ++++++++++++
 2 files changed

// File: rtl/compute_dispatch_if.sv
// rtl/compute_dispatch_if.sv - launch/complete handshake and result bundle for compute_dispatch
interface compute_dispatch_if #(
  parameter int DW   = 8,
  parameter int NENG = 3
);
  logic                   start;
  logic [2:0]             mode;
  logic                   send_req;
  logic                   send_ack;
  logic [NENG-1:0]        eng_start;
  logic [NENG-1:0]        eng_done;
  logic [NENG*4*DW-1:0]   eng_c;
  logic [DW-1:0]          c11;
  logic [DW-1:0]          c12;
  logic [DW-1:0]          c21;
  logic [DW-1:0]          c22;
  logic                   done;
  logic                   busy;
  logic                   err;

  modport slave (
    input  start, mode, send_req, eng_done, eng_c,
    output send_ack, eng_start, c11, c12, c21, c22, done, busy, err
  );

  modport master (
    output start, mode, send_req, eng_done, eng_c,
    input  send_ack, eng_start, c11, c12, c21, c22, done, busy, err
  );
endinterface

// File: rtl/compute_dispatch.sv
// rtl/compute_dispatch.sv - launches one of NENG engines and captures its 2x2 result
// Optional run timeout is built only when COMPUTE_DISPATCH_TIMEOUT_EN is defined.
module compute_dispatch #(
  parameter int DW     = 8,
  parameter int NENG   = 3,
  parameter int TO_CYC = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  compute_dispatch_if.slave    bus
);

  if (NENG < 2 || NENG > 8 || TO_CYC < 2 || TO_CYC > 65535 || DW < 1) begin : g_param_check
    $error("compute_dispatch: parameter out of range");
  end

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state_q;
  logic [2:0]        mode_q;
  logic [NENG-1:0]   eng_start_q;
  logic [DW-1:0]     c11_q, c12_q, c21_q, c22_q;
  logic              done_q;
  logic              err_q;
  logic              send_ack_q;

  logic              mode_legal;
  logic [NENG-1:0]   launch_onehot;
  logic              sel_done;
  logic [4*DW-1:0]   sel_c;
  logic              timeout;

  assign mode_legal = ({1'b0, bus.mode} < 4'(NENG));

  // Mux by comparison rather than indexing so a 3-bit mode never reaches past NENG.
  always_comb begin
    launch_onehot = '0;
    sel_done      = 1'b0;
    sel_c         = '0;
    for (int k = 0; k < NENG; k++) begin
      if (bus.mode == 3'(k)) launch_onehot[k] = 1'b1;
      if (mode_q == 3'(k)) begin
        sel_done = bus.eng_done[k];
        sel_c    = bus.eng_c[k*4*DW +: 4*DW];
      end
    end
  end

`ifdef COMPUTE_DISPATCH_TIMEOUT_EN
  localparam int TW = $clog2(TO_CYC + 1);
  logic [TW-1:0] timer_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  timer_q <= '0;
    else if (state_q == IDLE) timer_q <= '0;
    else                      timer_q <= timer_q + 1'b1;
  end

  assign timeout = (timer_q == TW'(TO_CYC - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mode_q      <= '0;
      eng_start_q <= '0;
      c11_q       <= '0;
      c12_q       <= '0;
      c21_q       <= '0;
      c22_q       <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      eng_start_q <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            if (mode_legal) begin
              mode_q      <= bus.mode;
              eng_start_q <= launch_onehot;
              state_q     <= RUN;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        RUN: begin
          // Completion takes priority over a coincident timeout.
          if (sel_done) begin
            {c11_q, c12_q, c21_q, c22_q} <= sel_c;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end else if (timeout) begin
            err_q   <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) send_ack_q <= 1'b0;
    else     send_ack_q <= bus.send_req;
  end

  assign bus.eng_start = eng_start_q;
  assign bus.c11       = c11_q;
  assign bus.c12       = c12_q;
  assign bus.c21       = c21_q;
  assign bus.c22       = c22_q;
  assign bus.done      = done_q;
  assign bus.busy      = (state_q == RUN);
  assign bus.err       = err_q;
  assign bus.send_ack  = send_ack_q;

endmodule
